// File: rtl/timer_irq_source.sv
`default_nettype none
// ============================================================================
//  Module   : timer_irq_source
//  Purpose  : Memory-mapped timer peripheral on the data-memory bus. Holds a
//             reload register (TH), an up-counter (TL), a control/status
//             register (TCON) and a free-running SysTick. An enabled TL
//             overflow raises a level interrupt (TCON[2]) that stays high
//             until software clears it with a TCON store.
//  Register map (byte offsets from BASE_ADDR, Address[1:0] ignored):
//             0x00 TH      reload value, R/W
//             0x04 TL      counter, R/W
//             0x08 TCON    [0] enable, [1] irq enable, [2] pending, R/W
//             0x0C/0x10    reserved: read 0, writes ignored, Hit asserted
//             0x14 SysTick free-running cycle count, read-only
//  Ports    : clk        system clock, all state on rising edge
//             reset      synchronous active-low reset
//             MemRead    MEM-stage load strobe
//             MemWrite   MEM-stage store strobe
//             Address    byte address
//             WriteData  store data
//             ReadData   combinational load data (0 unless MemRead && Hit)
//             Hit        address lies in the 6-word register window
//             Interrupt  level interrupt, equals TCON[2]
//  Revision : 1.0  initial release
// ============================================================================
module timer_irq_source #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned TCON_W    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        Interrupt
);

  // Word offsets within the register window
  localparam logic [29:0] C_OFF_TH      = 30'd0;
  localparam logic [29:0] C_OFF_TL      = 30'd1;
  localparam logic [29:0] C_OFF_TCON    = 30'd2;
  localparam logic [29:0] C_OFF_SYSTICK = 30'd5;

  logic [31:0]       r_th;
  logic [31:0]       r_tl;
  logic [TCON_W-1:0] r_tcon;
  logic [31:0]       r_systick;

  logic [29:0]       w_word_off;
  logic              w_hit;
  logic              w_wr;
  logic              w_wr_th;
  logic              w_wr_tl;
  logic              w_wr_tcon;
  logic              w_ovf;
  logic              w_irq_set;
  logic [31:0]       w_tl_next;
  logic [TCON_W-1:0] w_tcon_next;
  logic [31:0]       w_rdata;
  logic              w_unused;

  // Byte lane bits play no part in decoding
  assign w_unused = &{1'b0, Address[1:0]};

  // Subtracting the base makes addresses below it wrap to a large offset,
  // so a single unsigned compare bounds both ends of the window.
  assign w_word_off = Address[31:2] - BASE_ADDR[31:2];
  assign w_hit      = (w_word_off <= C_OFF_SYSTICK);

  assign w_wr      = MemWrite && w_hit;
  assign w_wr_th   = w_wr && (w_word_off == C_OFF_TH);
  assign w_wr_tl   = w_wr && (w_word_off == C_OFF_TL);
  assign w_wr_tcon = w_wr && (w_word_off == C_OFF_TCON);

  // Overflow is judged on the current (pre-write) enable. A CPU store to TL
  // in the same cycle overrides the reload and suppresses the pending set.
  assign w_ovf     = r_tcon[0] && (r_tl == 32'hFFFF_FFFF);
  assign w_irq_set = w_ovf && r_tcon[1] && !w_wr_tl;

  always_comb begin
    w_tl_next = r_tl;
    if (w_wr_tl) begin
      w_tl_next = WriteData;
    end else if (r_tcon[0]) begin
      // Reload uses the current TH even if TH is being written this cycle
      w_tl_next = w_ovf ? r_th : (r_tl + 32'd1);
    end
  end

  always_comb begin
    w_tcon_next = r_tcon;
    if (w_wr_tcon) begin
      w_tcon_next = WriteData[TCON_W-1:0];
    end
    // A hardware set wins over a software clear in the same cycle
    if (w_irq_set) begin
      w_tcon_next[2] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_th      <= '0;
      r_tl      <= '0;
      r_tcon    <= '0;
      r_systick <= '0;
    end else begin
      r_systick <= r_systick + 32'd1;
      r_tl      <= w_tl_next;
      r_tcon    <= w_tcon_next;
      if (w_wr_th) begin
        r_th <= WriteData;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (MemRead && w_hit) begin
      case (w_word_off)
        C_OFF_TH:      w_rdata = r_th;
        C_OFF_TL:      w_rdata = r_tl;
        C_OFF_TCON:    w_rdata = {{(32-TCON_W){1'b0}}, r_tcon};
        C_OFF_SYSTICK: w_rdata = r_systick;
        default:       w_rdata = '0;
      endcase
    end
  end

  assign ReadData  = w_rdata;
  assign Hit       = w_hit;
  assign Interrupt = r_tcon[2];

endmodule
`default_nettype wire

// File: doc/timer_irq_source.md
Name: timer_irq_source

Overview:
- Memory-mapped timer peripheral on the data-memory bus; it is the interrupt-generating end of the pipeline's Interrupt input.
- Holds a reload register (TH), a up-counter (TL), a control/status register (TCON) and a free-running SysTick.
- On TL overflow with interrupts enabled, it asserts a level Interrupt. The signal stays high until software, in the handler, clears TCON[2] by a store.
- The control unit masks Interrupt in kernel mode (PC_sign); this block does no masking.

Parameters:
- BASE_ADDR, 32'h40000000, word address of TH; TL = +4, TCON = +8, SysTick = +20.
- TCON_W, 3, implemented TCON bits; upper bits read 0.

Ports:
- clk        input   1   system clock, all state on rising edge
- reset      input   1   synchronous, active-low reset; sampled on rising clk edge
- MemRead    input   1   MEM-stage load strobe
- MemWrite   input   1   MEM-stage store strobe
- Address    input   32  byte address from ALU result
- WriteData  input   32  store data
- ReadData   output  32  load data, combinational from Address/MemRead
- Hit        output  1   Address decodes to one of the four registers or a reserved slot in [BASE_ADDR, BASE_ADDR+20]
- Interrupt  output  1   equals TCON[2]

Behaviour:
- Reset (reset==0 at clk edge): TH=0, TL=0, TCON=0, SysTick=0; so Interrupt=0.
  - ReadData and Hit are combinational and have no reset value; they depend only on inputs and the reset-cleared state.
  - Reset mid-count or with the interrupt pending clears everything in that same edge.
- Address decode: Address[1:0] are ignored; the match is on Address[31:2].
  - Offsets 0x0C and 0x10 are reserved: they read 0, ignore writes, and assert Hit.
  - Any other address gives Hit=0 and ReadData=0.
- Read: ReadData = selected register when MemRead && Hit, else 0. Zero-latency, same cycle, for MEM-stage use.
  - TCON reads as {29'b0, TCON[2:0]}.
- Write: registered at the clk edge when MemWrite && Hit.
  - TH and TL take the full 32 bits.
  - TCON takes WriteData[2:0]. Writing 1 to bit 2 sets the pending flag; this is allowed as a software-triggered interrupt.
  - SysTick is read-only; writes to it are ignored.
- Counting, each edge with TCON[0]==1 and no CPU write to TL in that cycle:
  - TL==32'hFFFFFFFF: TL<=TH (overflow/reload). If TCON[1], TCON[2]<=1.
  - Otherwise TL<=TL+1 (32-bit, no saturation).
- TCON[0]==0: TL holds and no overflow occurs; the TCON[2] state is retained.
- SysTick increments every non-reset cycle and wraps at 2^32 with no flag.
- Simultaneous events, all at the same edge:
  - CPU write to TL on an overflow edge: the written value wins; no reload and no pending set from that overflow.
  - CPU write to TH on an overflow edge: the reload uses the old TH; TH takes the new value.
  - CPU write to TCON on an overflow edge with TCON[1] (old value) ==1: bits [1:0] take WriteData[1:0]. TCON[2] = WriteData[2] OR 1, so the set wins and no interrupt is lost.
  - Enable is judged on the old TCON value. A write that sets TCON[0] starts counting on the next edge.
- MemRead and MemWrite both high: the read is served combinationally (pre-write value) and the write commits at the edge.
- Interrupt is a level signal. No edge detection and no acknowledge port; it is cleared only by reset or by a TCON write with bit 2 = 0 (subject to the set-wins rule).

Test Plan:
- Reset: hold reset=0 for 2 cycles with random bus activity -> TH=TL=TCON=SysTick=0, Interrupt=0; SysTick reads 1 one cycle after release.
- Periodic interrupt:
  - Write TH=32'hFFFFFFFC, TL=32'hFFFFFFFC, then TCON=3'b011.
  - Required: TL reads FFFFFFFD..FFFFFFFF on successive cycles; the next edge gives TL=FFFFFFFC and Interrupt=1.
  - Interrupt then reasserts every 4 cycles after each clear.
- Clear vs set race: arrange the TCON write of 3'b011 on exactly the overflow edge -> Interrupt stays 1. The same write one cycle earlier -> Interrupt drops to 0 for 1 cycle, then rises.
- TL-write race: write TL=32'h00000010 on the overflow edge -> TL=0x10 next cycle, Interrupt unchanged (0). Counting resumes 0x11, 0x12.
- Decode:
  - Read BASE+0x0C -> Hit=1, ReadData=0.
  - Read BASE+0x18 or 0x00000010 -> Hit=0, ReadData=0.
  - Read BASE+0x0B -> returns TCON.
  - Write SysTick -> value unchanged.
- Disabled hold: TCON=3'b110 with TL=5 -> TL stays 5 for 10 cycles and Interrupt stays 1 until a TCON write of 0.
